strip_config_sequencer: RTL and testbench
=========================================

# strip_config_sequencer

- Sits between the button encoder and the filter coefficient banks.
- When a new frequency, lowpass or highpass selection arrives, or when mute is requested, it soft-fades the channel gain to zero.
- With gain at zero it commits the new selections and loads coefficients through a req/ack handshake, then fades back in, so coefficient swaps never produce audible clicks.
- All ramp steps are paced by the 48 kHz sample strobe.

## Interface

- Parameters:
  - GAIN_W, 8: gain output width; full scale (2^GAIN_W-1) is unity.
  - STEP, 4: gain increment/decrement per sample_tick.
  - ACK_TIMEOUT, 1024: maximum clk_48 cycles spent in WAIT_ACK.
- Ports (single clock domain; reset is synchronous and active-high):
  - clk_48 in 1: system clock; all state updates on its rising edge.
  - reset in 1: synchronous, active-high.
  - sample_tick in 1: one-cycle strobe per audio sample.
  - freq_sel_in in 3: requested frequency selection.
  - lp_sel_in in 3: requested lowpass selection.
  - hp_sel_in in 3: requested highpass selection.
  - mute_in in 1: level mute request.
  - coef_ack in 1: coefficient bank reports that its load is complete.
  - freq_sel out 3: committed selection driving the datapath.
  - lp_sel out 3: committed selection driving the datapath.
  - hp_sel out 3: committed selection driving the datapath.
  - coef_req out 1: coefficient load request, held until acked.
  - gain out GAIN_W: channel gain multiplier.
  - busy out 1: high in any state except IDLE and MUTED.
  - timeout_err out 1: sticky flag, set when a load is not acked in time.

## Operation

- **States:** LOAD, WAIT_ACK, FADE_IN, IDLE, FADE_OUT, MUTED.
- **Reset values:** state=LOAD, freq_sel=4, lp_sel=1, hp_sel=2, gain=0, coef_req=0, timeout_err=0.
  - busy is decoded from state, so it is 1 during reset.
  - The first cycle after reset loads the default coefficients.
- **pending** = {freq_sel_in, lp_sel_in, hp_sel_in} != {freq_sel, lp_sel, hp_sel}, evaluated every cycle.
- **IDLE** (gain at full scale):
  - pending or mute_in → FADE_OUT.
- **FADE_OUT:**
  - On each sample_tick: gain = max(gain-STEP, 0).
  - In the cycle where gain==0, exit priority is: pending → LOAD; else mute_in → MUTED; else → FADE_IN (the request was withdrawn).
- **LOAD** (one cycle):
  - Snapshot the *_sel_in inputs into the *_sel outputs, set coef_req=1, go to WAIT_ACK.
- **WAIT_ACK:**
  - Hold coef_req and the selects stable.
  - On coef_ack=1: coef_req=0 and timeout_err=0 next cycle. Exit priority: pending → LOAD; else mute_in → MUTED; else → FADE_IN.
  - If ACK_TIMEOUT cycles pass without ack: coef_req=0, timeout_err=1, → MUTED.
- **MUTED** (gain held at 0):
  - pending → LOAD.
  - Else if !mute_in and !timeout_err → FADE_IN.
- **FADE_IN:**
  - On each sample_tick: gain = min(gain+STEP, 2^GAIN_W-1).
  - pending or mute_in in any cycle → FADE_OUT, starting from the current gain with no jump.
  - gain at full scale → IDLE.
- **Arithmetic:**
  - Ramps are computed in GAIN_W+1 bits and saturate at both ends; gain never wraps.
- **Ordering guarantee:**
  - Selects and coef_req never change while gain != 0.

## Timing

- A state transition takes effect on the clock edge after its condition is sampled.
- Handshake sequence:
  - coef_req rises the cycle after LOAD, together with the new selects.
  - coef_ack is sampled on every clk_48 edge while in WAIT_ACK.
  - coef_req falls the cycle after ack is seen.
  - An ack outside WAIT_ACK is ignored.
- Timeout: the cycle counter clears on entry to WAIT_ACK; timeout fires when the counter reaches ACK_TIMEOUT-1 with no ack.
- Ramp length with defaults: 255→0 takes 64 ticks (3 is followed by 0), about 1.33 ms; 0→255 also takes 64 ticks.
- Gain changes only on sample_tick cycles. sample_tick outside FADE_IN/FADE_OUT has no effect.
- Ack and timeout in the same cycle: ack wins.
- Selection change and mute in the same cycle: pending has priority at every decision point.
- Reset asserted mid-operation: all state and outputs return to their reset values on the next edge.

## Test plan

- **Reset release, ack after 3 cycles:**
  - Selects are 4/1/2; coef_req rises on cycle 2.
  - After the ack, gain ramps 0→255 over 64 ticks; busy falls when gain reaches 255.
- **lp_sel_in 1→3 in IDLE:**
  - gain ramps 255→0 in 64 ticks while lp_sel stays 1.
  - Then lp_sel=3 and coef_req=1; after the ack, gain fades back to 255.
- **mute_in=1 in IDLE:**
  - gain reaches 0, state MUTED, coef_req never asserted.
  - mute_in=0 → gain returns to 255 in 64 ticks.
- **hp_sel_in changes during FADE_IN at gain=128:**
  - The fade reverses from 128 (next tick gives 124) with no jump.
  - A load follows, then a fade-in.
- **ACK_TIMEOUT=16, no ack:**
  - timeout_err=1 after 16 cycles, coef_req=0, gain held at 0.
  - A new selection with ack clears timeout_err and fades in.
- **freq_sel_in changes during WAIT_ACK:**
  - After the ack, a second LOAD runs immediately, giving two coef_req pulses.
  - gain stays 0 throughout, then fades in.

Source files
------------

// File: rtl/strip_config_sequencer.sv
// Click-free coefficient swap sequencer: fades gain to zero, commits new selections,
// loads coefficients over a req/ack handshake, then fades gain back to unity.
module strip_config_sequencer #(
  parameter int GAIN_W      = 8,
  parameter int STEP        = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk_48,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [2:0]        freq_sel_in,
  input  logic [2:0]        lp_sel_in,
  input  logic [2:0]        hp_sel_in,
  input  logic              mute_in,
  input  logic              coef_ack,
  output logic [2:0]        freq_sel,
  output logic [2:0]        lp_sel,
  output logic [2:0]        hp_sel,
  output logic              coef_req,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              timeout_err
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [GAIN_W:0] FULL_EXT = {1'b0, {GAIN_W{1'b1}}};
  localparam logic [GAIN_W:0] STEP_EXT = (GAIN_W + 1)'(STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD, WAIT_ACK, FADE_IN, IDLE, FADE_OUT, MUTED
  } state_t;

  state_t            state_q;
  logic [2:0]        freq_q, lp_q, hp_q;
  logic              req_q, terr_q;
  logic [GAIN_W-1:0] gain_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [GAIN_W:0]   gain_ext, up_sum;
  logic [GAIN_W-1:0] gain_up_d, gain_dn_d;
  logic              pending;

  // Ramp arithmetic carries one extra bit so both ends saturate instead of wrapping.
  always_comb begin
    gain_ext  = {1'b0, gain_q};
    up_sum    = gain_ext + STEP_EXT;
    gain_up_d = (up_sum > FULL_EXT) ? {GAIN_W{1'b1}} : GAIN_W'(up_sum);
    gain_dn_d = (gain_ext < STEP_EXT) ? '0 : GAIN_W'(gain_ext - STEP_EXT);
  end

  assign pending = {freq_sel_in, lp_sel_in, hp_sel_in} != {freq_q, lp_q, hp_q};

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_q <= LOAD;
      freq_q  <= 3'd4;
      lp_q    <= 3'd1;
      hp_q    <= 3'd2;
      gain_q  <= '0;
      req_q   <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          freq_q  <= freq_sel_in;
          lp_q    <= lp_sel_in;
          hp_q    <= hp_sel_in;
          req_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack arriving on the timeout cycle still counts as a successful load.
          if (coef_ack) begin
            req_q  <= 1'b0;
            terr_q <= 1'b0;
            if (pending)      state_q <= LOAD;
            else if (mute_in) state_q <= MUTED;
            else              state_q <= FADE_IN;
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            terr_q  <= 1'b1;
            state_q <= MUTED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FADE_IN: begin
          if (pending || mute_in)         state_q <= FADE_OUT;
          else if (gain_q == {GAIN_W{1'b1}}) state_q <= IDLE;
          else if (sample_tick)           gain_q  <= gain_up_d;
        end
        IDLE: begin
          if (pending || mute_in) state_q <= FADE_OUT;
        end
        FADE_OUT: begin
          if (gain_q == '0) begin
            if (pending)      state_q <= LOAD;
            else if (mute_in) state_q <= MUTED;
            else              state_q <= FADE_IN;
          end else if (sample_tick) begin
            gain_q <= gain_dn_d;
          end
        end
        MUTED: begin
          if (pending)                  state_q <= LOAD;
          else if (!mute_in && !terr_q) state_q <= FADE_IN;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign freq_sel    = freq_q;
  assign lp_sel      = lp_q;
  assign hp_sel      = hp_q;
  assign coef_req    = req_q;
  assign gain        = gain_q;
  assign timeout_err = terr_q;
  assign busy        = !(state_q == IDLE || state_q == MUTED);

endmodule

// File: tb/tb_strip_config_sequencer.sv
// Scoreboard bench for strip_config_sequencer: expected committed selections are queued
// when a change is driven and popped when coef_req rises.
module tb_strip_config_sequencer;

  logic       clk_48;
  logic       reset;
  logic       sample_tick;
  logic [2:0] freq_sel_in, lp_sel_in, hp_sel_in;
  logic       mute_in;
  logic       coef_ack;
  logic [2:0] freq_sel, lp_sel, hp_sel;
  logic       coef_req;
  logic [7:0] gain;
  logic       busy;
  logic       timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_loads  = 0;
  logic [8:0] sel_q[$];

  strip_config_sequencer #(
    .GAIN_W(8),
    .STEP(4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk_48(clk_48),
    .reset(reset),
    .sample_tick(sample_tick),
    .freq_sel_in(freq_sel_in),
    .lp_sel_in(lp_sel_in),
    .hp_sel_in(hp_sel_in),
    .mute_in(mute_in),
    .coef_ack(coef_ack),
    .freq_sel(freq_sel),
    .lp_sel(lp_sel),
    .hp_sel(hp_sel),
    .coef_req(coef_req),
    .gain(gain),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk_48 = 1'b0;
  always #5 clk_48 = ~clk_48;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Sample strobe every 4th clock, driven just after the active edge.
  initial begin
    int c;
    c = 0;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk_48);
      #1;
      c = (c + 1) % 4;
      sample_tick = (c == 0);
    end
  end

  // Monitor: ramp step legality, ordering guarantee, and scoreboard pops on coef_req rise.
  initial begin
    logic [7:0]  pg;
    logic        pt, pr, prst;
    logic [9:0]  pstate;
    logic [8:0]  e;
    int          ex;
    pg = '0; pt = 1'b0; pr = 1'b0; prst = 1'b1; pstate = '0;
    forever begin
      @(posedge clk_48);
      #2;
      if (!reset && !prst) begin
        if (gain !== pg) begin
          if (!pt)            ex = int'(pg);
          else if (gain > pg) ex = (int'(pg) + 4 > 255) ? 255 : int'(pg) + 4;
          else                ex = (int'(pg) < 4) ? 0 : int'(pg) - 4;
          check("ramp_step", gain, ex);
        end
        if ({freq_sel, lp_sel, hp_sel, coef_req} !== pstate)
          check("order_gain0", gain, 0);
        if (coef_req && !pr) begin
          check("sb_nonempty", sel_q.size() != 0, 1);
          if (sel_q.size() != 0) begin
            e = sel_q.pop_front();
            n_loads++;
            $display("load %0d: sel %0d/%0d/%0d expected %0d/%0d/%0d", n_loads,
                     freq_sel, lp_sel, hp_sel, e[8:6], e[5:3], e[2:0]);
            check("load_sel", {freq_sel, lp_sel, hp_sel}, e);
          end
        end
      end
      pg = gain; pt = sample_tick; pr = coef_req; prst = reset;
      pstate = {freq_sel, lp_sel, hp_sel, coef_req};
    end
  end

  // Waits (bounded) until gain reaches target, counting gain changes on the way.
  task automatic ramp_to(input int target, input int exp_steps, input string tag);
    int steps;
    logic [7:0] last;
    steps = 0;
    last = gain;
    for (int i = 0; i < 3000; i++) begin
      if (gain == target[7:0]) break;
      @(posedge clk_48);
      #2;
      if (gain != last) begin
        steps++;
        last = gain;
      end
    end
    check({tag, "_end"}, gain, target);
    check({tag, "_steps"}, steps, exp_steps);
  endtask

  // Waits (bounded) for coef_req, then acks after dly cycles; ends 2 time units past the ack edge.
  task automatic do_ack(input int dly, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (coef_req) break;
      @(posedge clk_48);
      #2;
    end
    check({tag, "_req_seen"}, coef_req, 1);
    repeat (dly) @(posedge clk_48);
    #1 coef_ack = 1'b1;
    @(posedge clk_48);
    #1 coef_ack = 1'b0;
    #1 check({tag, "_req_fall"}, coef_req, 0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (coef_req) break;
      @(posedge clk_48);
      #2;
    end
    check(tag, coef_req, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    freq_sel_in = 3'd4; lp_sel_in = 3'd1; hp_sel_in = 3'd2;
    mute_in = 1'b0; coef_ack = 1'b0;

    // Reset state and first default load
    repeat (3) @(posedge clk_48);
    #2;
    check("rst_gain", gain, 0);
    check("rst_req", coef_req, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_busy", busy, 1);
    check("rst_sel", {freq_sel, lp_sel, hp_sel}, {3'd4, 3'd1, 3'd2});
    sel_q.push_back({3'd4, 3'd1, 3'd2});
    @(posedge clk_48);
    #1 reset = 1'b0;
    #1 check("t1_req_pre", coef_req, 0);
    @(posedge clk_48);
    #2 check("t1_req_rise", coef_req, 1);
    do_ack(3, "t1");
    ramp_to(255, 64, "t1_in");
    @(posedge clk_48);
    #2 check("t1_idle_busy", busy, 0);

    // Stray ack in IDLE is ignored
    @(posedge clk_48);
    #1 coef_ack = 1'b1;
    @(posedge clk_48);
    #1 coef_ack = 1'b0;
    repeat (3) @(posedge clk_48);
    #2;
    check("stray_ack_gain", gain, 255);
    check("stray_ack_busy", busy, 0);
    check("stray_ack_req", coef_req, 0);

    // Lowpass change in IDLE
    lp_sel_in = 3'd3;
    sel_q.push_back({3'd4, 3'd3, 3'd2});
    ramp_to(0, 64, "t2_out");
    check("t2_lp_hold", lp_sel, 1);
    do_ack(2, "t2");
    check("t2_lp_new", lp_sel, 3);
    ramp_to(255, 64, "t2_in");

    // Mute and unmute, no load
    mute_in = 1'b1;
    ramp_to(0, 64, "t3_out");
    repeat (20) @(posedge clk_48);
    #2;
    check("t3_muted_busy", busy, 0);
    check("t3_muted_gain", gain, 0);
    check("t3_muted_req", coef_req, 0);
    mute_in = 1'b0;
    ramp_to(255, 64, "t3_in");

    // Highpass change mid fade-in reverses without a jump
    mute_in = 1'b1;
    ramp_to(0, 64, "t4_out");
    mute_in = 1'b0;
    ramp_to(128, 32, "t4_half");
    hp_sel_in = 3'd5;
    sel_q.push_back({3'd4, 3'd3, 3'd5});
    for (int i = 0; i < 50; i++) begin
      if (gain != 8'd128) break;
      @(posedge clk_48);
      #2;
    end
    check("t4_reverse", gain, 124);
    ramp_to(0, 31, "t4_out2");
    do_ack(1, "t4");
    ramp_to(255, 64, "t4_in");

    // Ack timeout, then recovery by a new selection
    freq_sel_in = 3'd1;
    sel_q.push_back({3'd1, 3'd3, 3'd5});
    ramp_to(0, 64, "t5_out");
    wait_req("t5_req");
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk_48);
      #2;
      n++;
      if (timeout_err) break;
    end
    check("t5_tmo_cycles", n, 16);
    check("t5_tmo_req", coef_req, 0);
    repeat (10) @(posedge clk_48);
    #2;
    check("t5_terr_sticky", timeout_err, 1);
    check("t5_gain_held", gain, 0);
    check("t5_busy", busy, 0);
    freq_sel_in = 3'd2;
    sel_q.push_back({3'd2, 3'd3, 3'd5});
    do_ack(2, "t5");
    check("t5_terr_clr", timeout_err, 0);
    ramp_to(255, 64, "t5_in");

    // Selection change during WAIT_ACK chains a second load
    freq_sel_in = 3'd3;
    sel_q.push_back({3'd3, 3'd3, 3'd5});
    ramp_to(0, 64, "t6_out");
    wait_req("t6_req");
    freq_sel_in = 3'd6;
    sel_q.push_back({3'd6, 3'd3, 3'd5});
    do_ack(2, "t6a");
    check("t6_gain0_a", gain, 0);
    do_ack(1, "t6b");
    check("t6_gain0_b", gain, 0);
    check("t6_freq", freq_sel, 6);
    ramp_to(255, 64, "t6_in");

    // Reset mid fade-out
    mute_in = 1'b1;
    repeat (40) @(posedge clk_48);
    #1 reset = 1'b1;
    mute_in = 1'b0;
    @(posedge clk_48);
    #2;
    check("t7_gain", gain, 0);
    check("t7_req", coef_req, 0);
    check("t7_busy", busy, 1);
    check("t7_sel", {freq_sel, lp_sel, hp_sel}, {3'd4, 3'd1, 3'd2});
    sel_q.push_back({3'd6, 3'd3, 3'd5});
    @(posedge clk_48);
    #1 reset = 1'b0;
    #1;
    do_ack(3, "t7");
    ramp_to(255, 64, "t7_in");

    check("sb_empty", sel_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
